// File: rtl/alu_arb_if.sv
// Bundle of the two requester channels, the two response channels and the
// shared ALU connection used by alu_arb.
interface alu_arb_if;
  // Request side
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req0_op;
  logic [3:0]  req1_op;

  // Response side
  logic        resp0_valid;
  logic        resp1_valid;
  logic        resp0_ready;
  logic        resp1_ready;
  logic [31:0] resp_data;

  // Shared combinational ALU
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, resp0_ready, resp1_ready, alu_out,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
           alu_in0, alu_in1, alu_op
  );

  // Requesters plus ALU (environment side)
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_op, req1_op, resp0_ready, resp1_ready, alu_out,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
           alu_in0, alu_in1, alu_op
  );
endinterface

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC captures the ALU result,
// RESP holds the result until the owning requester takes it.
module alu_arb (
  input  logic      clk,
  input  logic      rst,
  alu_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;      // last requester granted (1 => req0 wins next tie)
  logic        owner_q, owner_d;  // requester owning the operation in flight
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] res_q, res_d;

  logic        grant0;
  logic        grant1;
  logic        resp_hs;

  // Round-robin winner among the currently valid requesters
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ptr_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~ptr_q);
  end

  // Response handshake only counts for the owner's ready
  always_comb begin
    resp_hs = 1'b0;
    if (state_q == RESP) begin
      resp_hs = owner_q ? bus.resp1_ready : bus.resp0_ready;
    end
  end

  // Next-state, register capture and handshake outputs
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    a_d             = a_q;
    b_d             = b_q;
    op_d            = op_q;
    res_d           = res_q;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (grant0 || grant1) begin
          owner_d = grant1;
          ptr_d   = grant1;
          a_d     = grant1 ? bus.req1_a  : bus.req0_a;
          b_d     = grant1 ? bus.req1_b  : bus.req0_b;
          op_d    = grant1 ? bus.req1_op : bus.req0_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_out;
        state_d = RESP;
      end
      RESP: begin
        bus.resp0_valid = ~owner_q;
        bus.resp1_valid = owner_q;
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // ALU is fed from the operand registers at all times
  always_comb begin
    bus.alu_in0   = a_q;
    bus.alu_in1   = b_q;
    bus.alu_op    = op_q;
    bus.resp_data = res_q;
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb with a small combinational ALU model.
module tb_alu_arb;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned fails;

  alu_arb_if bus ();

  alu_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment ALU
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_out = bus.alu_in0 + bus.alu_in1;
      OP_SUB:  bus.alu_out = bus.alu_in0 - bus.alu_in1;
      default: bus.alu_out = bus.alu_in0 & bus.alu_in1;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    tick();
    #1;
    // Reset state: IDLE, pointer favours req0
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_rv0", {31'd0, bus.resp0_valid}, 32'd0);
    chk("rst_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    chk("rst_in0", bus.alu_in0, 32'd0);
    chk("rst_data", bus.resp_data, 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single request 5+3
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_op = OP_ADD;
    bus.resp0_ready = 1'b1;
    #1;
    chk("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("single_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("single_exec_rv0", {31'd0, bus.resp0_valid}, 32'd0);
    chk("single_exec_in0", bus.alu_in0, 32'd5);
    chk("single_exec_in1", bus.alu_in1, 32'd3);
    tick();
    chk("single_rv0", {31'd0, bus.resp0_valid}, 32'd1);
    chk("single_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    chk("single_data", bus.resp_data, 32'd8);
    tick();
    chk("single_done_rv0", {31'd0, bus.resp0_valid}, 32'd0);
    bus.resp0_ready = 1'b0;

    // Contention from reset: req0, req1, req0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd10;  bus.req0_b = 32'd20; bus.req0_op = OP_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd100; bus.req1_b = 32'd7;  bus.req1_op = OP_SUB;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    chk("cont1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("cont1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    tick();
    chk("cont1_rv0", {31'd0, bus.resp0_valid}, 32'd1);
    chk("cont1_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    chk("cont1_data", bus.resp_data, 32'd30);
    chk("cont1_resp_readies", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    tick();
    chk("cont2_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("cont2_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    tick();
    chk("cont2_rv1", {31'd0, bus.resp1_valid}, 32'd1);
    chk("cont2_rv0", {31'd0, bus.resp0_valid}, 32'd0);
    chk("cont2_data", bus.resp_data, 32'd93);
    tick();
    chk("cont3_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("cont3_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    tick();
    chk("cont3_rv0", {31'd0, bus.resp0_valid}, 32'd1);
    chk("cont3_data", bus.resp_data, 32'd30);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    // Pointer now 0 (req0 was last granted)

    // Backpressure on req1; req0 also held valid and must be ignored meanwhile
    bus.req1_valid = 1'b1; bus.req1_a = 32'h1234_5678; bus.req1_b = 32'h1111_1111; bus.req1_op = OP_ADD;
    #1;
    chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv1", {31'd0, bus.resp1_valid}, 32'd1);
      chk("bp_data", bus.resp_data, 32'h2345_6789);
      chk("bp_readies", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      tick();
    end
    bus.resp1_ready = 1'b1;
    #1;
    chk("bp_hold_rv1", {31'd0, bus.resp1_valid}, 32'd1);
    tick();
    chk("bp_idle_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    chk("bp_rearb_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("bp_rearb_ready1", {31'd0, bus.req1_ready}, 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.resp1_ready = 1'b0;

    // Non-owner ready must not complete req0's response
    bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd2; bus.req0_op = OP_SUB;
    bus.resp1_ready = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    tick();
    chk("nonown_rv0_a", {31'd0, bus.resp0_valid}, 32'd1);
    chk("nonown_data", bus.resp_data, 32'd5);
    tick();
    chk("nonown_rv0_b", {31'd0, bus.resp0_valid}, 32'd1);
    chk("nonown_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    bus.resp0_ready = 1'b1;
    tick();
    chk("nonown_done", {31'd0, bus.resp0_valid}, 32'd0);
    bus.resp0_ready = 1'b0;

    // Reset asserted while in EXEC aborts the operation
    bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd9; bus.req1_op = OP_ADD;
    tick();
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    chk("mrst_in0", bus.alu_in0, 32'd0);
    chk("mrst_in1", bus.alu_in1, 32'd0);
    chk("mrst_op", {28'd0, bus.alu_op}, 32'd0);
    chk("mrst_data", bus.resp_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mrst_after_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    bus.req1_valid = 1'b1; bus.req1_a = 32'd4; bus.req1_b = 32'd6; bus.req1_op = OP_ADD;
    #1;
    chk("mrst_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("mrst_exec_rv1", {31'd0, bus.resp1_valid}, 32'd0);
    tick();
    chk("mrst_rv1_lat2", {31'd0, bus.resp1_valid}, 32'd1);
    chk("mrst_result", bus.resp_data, 32'd10);
    tick();
    chk("mrst_done", {31'd0, bus.resp1_valid}, 32'd0);
    bus.resp1_ready = 1'b0;

    // Full-width pass-through: 0xFFFFFFFF - 1
    bus.req0_valid = 1'b1; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1; bus.req0_op = OP_SUB;
    bus.resp0_ready = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("pass_in0", bus.alu_in0, 32'hFFFF_FFFF);
    chk("pass_in1", bus.alu_in1, 32'd1);
    chk("pass_op", {28'd0, bus.alu_op}, {28'd0, OP_SUB});
    tick();
    chk("pass_rv0", {31'd0, bus.resp0_valid}, 32'd1);
    chk("pass_data", bus.resp_data, 32'hFFFF_FFFE);
    tick();
    chk("pass_done", {31'd0, bus.resp0_valid}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
